ask4_symbol_slicer: RTL and testbench

- Downstream of the receive matched filter (`RCV_filt`).
- Decimates the 1s17 matched-filter output at a selectable sampling phase and slices each decision sample into a Gray-coded 4-ASK symbol.
- Tracks a block-averaged reference level that sets the outer decision thresholds.
- Output feeds the symbol checker/BER counter on the receive side.

---
 rtl/ask4_pkg.sv | 27 ++
 rtl/ask4_ref_est.sv | 83 ++++++++
 rtl/ask4_symbol_slicer.sv | 152 +++++++++++++++
 tb/tb_ask4_symbol_slicer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ask4_pkg.sv
// Shared 4-ASK definitions: sample type, Gray symbol encoding and level-to-symbol mapping
// used by both the receive slicer and the transmit-side symbol mapper.
package ask4_pkg;

    typedef logic signed [17:0] sample_t;

    typedef enum logic [1:0] {
        GRAY_M3 = 2'b00,
        GRAY_M1 = 2'b01,
        GRAY_P1 = 2'b11,
        GRAY_P3 = 2'b10
    } ask_sym_t;

    localparam int S1P17_MAX = 131071;

    // Level index 0..3 runs from -3a up to +3a; adjacent levels differ in one bit.
    function automatic ask_sym_t gray_map(input logic [1:0] level);
        case (level)
            2'd0:    gray_map = GRAY_M3;
            2'd1:    gray_map = GRAY_M1;
            2'd2:    gray_map = GRAY_P1;
            2'd3:    gray_map = GRAY_P3;
            default: gray_map = GRAY_M3;
        endcase
    endfunction

endpackage

// File: rtl/ask4_ref_est.sv
// Reference-level estimator: block-averages the saturated magnitude of decision samples
// over 2^ACC_LOG2 symbols to produce the outer decision threshold.
module ask4_ref_est
    import ask4_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int ACC_LOG2 = 7,
    parameter int INIT_REF = 65536
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic                     dec_i,
    output logic [DATA_W-1:0]        ref_level_o,
    output logic                     ref_valid_o
);

    localparam int MAG_W = DATA_W - 1;
    localparam int ACC_W = MAG_W + ACC_LOG2;

    logic [DATA_W-1:0]   abs_s;
    logic [MAG_W-1:0]    mag_s;
    logic [ACC_W-1:0]    sum_s;
    logic                blk_end_s;
    logic [ACC_W-1:0]    acc_d, acc_q;
    logic [ACC_LOG2-1:0] cnt_d, cnt_q;
    logic [DATA_W-1:0]   ref_d, ref_q;
    logic                ref_valid_d, ref_valid_q;

    // Magnitude; only the most negative code negates onto itself, so its MSB flags saturation.
    always_comb begin
        if (x_i[DATA_W-1]) begin
            abs_s = DATA_W'(-x_i);
        end else begin
            abs_s = x_i;
        end
        if (abs_s[DATA_W-1]) begin
            mag_s = {MAG_W{1'b1}};
        end else begin
            mag_s = abs_s[MAG_W-1:0];
        end
    end

    // Accumulate at each decision; the block-closing sample is folded into the average.
    always_comb begin
        sum_s       = acc_q + {{ACC_LOG2{1'b0}}, mag_s};
        blk_end_s   = dec_i && (cnt_q == {ACC_LOG2{1'b1}});
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        if (blk_end_s) begin
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {ACC_LOG2{1'b0}};
            ref_d       = {1'b0, sum_s[ACC_W-1:ACC_LOG2]};
            ref_valid_d = 1'b1;
        end else if (dec_i) begin
            acc_d = sum_s;
            cnt_d = cnt_q + ACC_LOG2'(1);
        end else begin
            acc_d = acc_q;
        end
    end

    // Estimator state registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {ACC_LOG2{1'b0}};
            ref_q       <= DATA_W'(INIT_REF);
            ref_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
        end
    end

    assign ref_level_o = ref_q;
    assign ref_valid_o = ref_valid_q;

endmodule

// File: rtl/ask4_symbol_slicer.sv
// 4-ASK symbol slicer: decimates at a latched sampling phase and slices to Gray symbols.
// Define ASK4_SLICER_ERR_EN to build the saturated decision-error output on err.
module ask4_symbol_slicer
    import ask4_pkg::*;
#(
    parameter int SPS      = 4,
    parameter int ACC_LOG2 = 7,
    parameter int DATA_W   = 18,
    parameter int INIT_REF = 65536
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic [$clog2(SPS)-1:0]   ph_sel,
    output logic                     sym_valid,
    output logic [1:0]               sym,
    output logic [DATA_W-1:0]        ref_level,
    output logic                     ref_valid,
    output logic signed [DATA_W-1:0] err
);

    localparam int              PH_W     = $clog2(SPS);
    localparam logic [PH_W-1:0] CNT_LAST = PH_W'(SPS - 1);

    logic [PH_W-1:0]          cnt_d, cnt_q;
    logic [PH_W-1:0]          ph_d, ph_q;
    logic                     dec_s;
    logic [DATA_W-1:0]        ref_level_s;
    logic                     ref_valid_s;
    logic signed [DATA_W-1:0] r_s, neg_r_s;
    logic [1:0]               level_s;
    ask_sym_t                 sym_d, sym_q;
    logic                     sym_valid_d, sym_valid_q;

    ask4_ref_est #(
        .DATA_W   (DATA_W),
        .ACC_LOG2 (ACC_LOG2),
        .INIT_REF (INIT_REF)
    ) u_ref_est (
        .clk         (clk),
        .reset       (reset),
        .x_i         (x_in),
        .dec_i       (dec_s),
        .ref_level_o (ref_level_s),
        .ref_valid_o (ref_valid_s)
    );

    // Phase is only re-latched at the window end so a change can never add a second decision.
    always_comb begin
        cnt_d = cnt_q + PH_W'(1);
        if (cnt_q == CNT_LAST) begin
            ph_d = ph_sel;
        end else begin
            ph_d = ph_q;
        end
        dec_s = (cnt_q == ph_q);
    end

    // Decision regions; ties resolve to the higher level.
    always_comb begin
        r_s     = $signed(ref_level_s);
        neg_r_s = -r_s;
        if (x_in >= r_s) begin
            level_s = 2'd3;
        end else if (!x_in[DATA_W-1]) begin
            level_s = 2'd2;
        end else if (x_in >= neg_r_s) begin
            level_s = 2'd1;
        end else begin
            level_s = 2'd0;
        end
    end

    // Symbol output next state: capture at the decision instant, hold otherwise.
    always_comb begin
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        if (dec_s) begin
            sym_d       = gray_map(level_s);
            sym_valid_d = 1'b1;
        end else begin
            sym_d = sym_q;
        end
    end

    // Phase counter, latched phase and symbol output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= {PH_W{1'b0}};
            ph_q        <= {PH_W{1'b0}};
            sym_q       <= GRAY_M3;
            sym_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign ref_level = ref_level_s;
    assign ref_valid = ref_valid_s;

`ifdef ASK4_SLICER_ERR_EN
    localparam int EW = DATA_W + 2;
    localparam logic signed [EW-1:0] ERR_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [EW-1:0] ERR_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    logic signed [EW-1:0]     r_w_s, half_s, ideal_s, diff_s;
    logic signed [DATA_W-1:0] err_d, err_q;

    // Two guard bits: ideal reaches 1.5*R and the difference can span twice full scale.
    always_comb begin
        r_w_s  = {{2{r_s[DATA_W-1]}}, r_s};
        half_s = r_w_s >>> 1;
        case (level_s)
            2'd3:    ideal_s = r_w_s + half_s;
            2'd2:    ideal_s = half_s;
            2'd1:    ideal_s = -half_s;
            2'd0:    ideal_s = -r_w_s - half_s;
            default: ideal_s = {EW{1'b0}};
        endcase
        diff_s = {{2{x_in[DATA_W-1]}}, x_in} - ideal_s;
        err_d  = err_q;
        if (!dec_s) begin
            err_d = err_q;
        end else if (diff_s > ERR_MAX) begin
            err_d = ERR_MAX[DATA_W-1:0];
        end else if (diff_s < ERR_MIN) begin
            err_d = ERR_MIN[DATA_W-1:0];
        end else begin
            err_d = diff_s[DATA_W-1:0];
        end
    end

    // Error register, updated in step with the symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= {DATA_W{1'b0}};
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_ask4_symbol_slicer.sv
// Directed self-checking bench for ask4_symbol_slicer (SPS=4, ACC_LOG2=7, INIT_REF=65536).
module tb_ask4_symbol_slicer;
    import ask4_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    sample_t            x_in = '0;
    logic [1:0]         ph_sel = 2'd0;
    logic               sym_valid;
    logic [1:0]         sym;
    logic [17:0]        ref_level;
    logic               ref_valid;
    logic signed [17:0] err;

    int checks   = 0;
    int failures = 0;

    int         lv2 [4] = '{-98304, -32768, 32768, 98304};
    logic [1:0] gs2 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         tv3 [4] = '{65536, 0, -65536, -65537};
    logic [1:0] ts3 [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int         gap5 [6] = '{4, 7, 4, 4, 4, 4};

    always #5 clk = ~clk;

    ask4_symbol_slicer dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .ph_sel    (ph_sel),
        .sym_valid (sym_valid),
        .sym       (sym),
        .ref_level (ref_level),
        .ref_valid (ref_valid),
        .err       (err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        chk("rst_valid", sym_valid, 0);
        chk("rst_sym", sym, 0);
        chk("rst_ref", ref_level, 65536);
        chk("rst_refv", ref_valid, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
    endtask

    // Constant input with ph_sel=0: strobes on cycles 1,5,9,...; threshold updates with pulse 128.
    task automatic run_const(input int val, input logic [1:0] exp_sym, input int new_ref, input int npulses);
        int p;
        logic [1:0] es;
        p  = 0;
        es = 2'b00;
        for (int c = 0; c < 4 * npulses; c++) begin
            x_in = sample_t'(val);
            tick();
            if (c % 4 == 0) begin
                p++;
                es = exp_sym;
            end
            chk("const_valid", sym_valid, (c % 4 == 0));
            chk("const_sym", sym, es);
            chk("const_ref", ref_level, (p >= 128) ? new_ref : 65536);
            chk("const_refv", ref_valid, (p >= 128));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, last, gi, cyc;
        logic [1:0] es;
        logic dec;

        // Test 1: constant 98304, two full blocks plus margin.
        ph_sel = 2'd0;
        x_in   = sample_t'(98304);
        do_reset(20);
        run_const(98304, 2'b10, 98304, 258);

        // Test 2: repeating pattern, ph_sel=2 (first decision still at phase 0).
        ph_sel = 2'd2;
        do_reset(3);
        k  = 0;
        es = 2'b00;
        for (int c = 0; c < 520; c++) begin
            x_in = sample_t'(lv2[(c / 4) % 4]);
            tick();
            dec = (c == 0) || (c >= 6 && (c % 4 == 2));
            if (dec) begin
                es = gs2[k % 4];
                k++;
            end
            chk("pat_valid", sym_valid, dec);
            chk("pat_sym", sym, es);
            chk("pat_err", err, 0);
            chk("pat_ref", ref_level, 65536);
            chk("pat_refv", ref_valid, (k >= 128));
        end

        // Test 3: threshold ties at R=65536.
        ph_sel = 2'd0;
        do_reset(2);
        for (int c = 0; c < 16; c++) begin
            x_in = sample_t'(tv3[c / 4]);
            tick();
            if (c % 4 == 0) begin
                chk("tie_valid", sym_valid, 1);
                chk("tie_sym", sym, ts3[c / 4]);
            end else begin
                chk("tie_novalid", sym_valid, 0);
            end
        end

        // Test 4: most negative input saturates the magnitude.
        do_reset(2);
        run_const(-131072, 2'b00, 131071, 130);

        // Test 5: phase change 0 -> 3 mid-symbol.
        ph_sel = 2'd0;
        do_reset(2);
        last = 0;
        gi   = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) ph_sel = 2'd3;
            x_in = sample_t'(0);
            tick();
            cyc = c + 1;
            chk("ph_valid", sym_valid, (cyc inside {1, 5, 12, 16, 20, 24, 28}));
            if (sym_valid === 1'b1) begin
                chk("ph_sym", sym, 2'b11);
                if (last > 0 && gi < 6) begin
                    chk("ph_gap", cyc - last, gap5[gi]);
                    gi++;
                end
                last = cyc;
            end
        end
        chk("ph_gapcount", gi, 6);

        // Test 6: reset at symbol 70 discards the partial block.
        ph_sel = 2'd0;
        do_reset(2);
        run_const(98304, 2'b10, 98304, 70);
        do_reset(3);
        run_const(98304, 2'b10, 98304, 130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
